serial_frame_sequencer: RTL and testbench
=========================================

// Module: serial_frame_sequencer
// PURPOSE
//  Sequences a serial frame receiver/router: detects a start bit on ser_in, captures a port address and a
//  payload length (MSB first), then routes exactly len payload bits to the addressed output lane.
//  Sits between the serial line and the per-port output buffers and owns all bit counting internally.
// PARAMETERS
//  PORT_W   2   address field width in bits; N_PORTS = 2**PORT_W output lanes
//  LEN_W    4   length field width in bits; payload 0..2**LEN_W-1 bits
// PORTS
//  clk        in   1        single clock, all state updates on posedge
//  rst        in   1        synchronous, active-high reset
//  ser_in     in   1        serial line, idles high; start bit = 0
//  abort      in   1        synchronous frame abort
//  ser_out    out  N_PORTS  routed payload bit, only addressed lane may be 1
//  out_valid  out  N_PORTS  one-hot qualifier for ser_out
//  port_sel   out  PORT_W   captured address, held until next frame's address completes
//  busy       out  1        1 in every state except IDLE
//  done       out  1        one-cycle end-of-frame pulse
// BEHAVIOUR
//  Reset: state=IDLE; ser_out, out_valid, port_sel, done = 0; busy = 0; counters and shift regs = 0.
//  rst has priority over abort and all other inputs.
//  States: IDLE -> PORT -> LEN -> DATA -> DONE -> IDLE.
//   IDLE: ser_in==0 sampled -> PORT; ser_in==1 -> stay.
//   PORT: shift ser_in into addr reg MSB first, PORT_W cycles; after last bit -> LEN; port_sel updated
//         from addr reg in the cycle following the last address bit.
//   LEN:  shift LEN_W bits MSB first; after last bit: len==0 -> DONE, else -> DATA.
//   DATA: exactly len cycles; each sampled ser_in bit appears registered on ser_out[port_sel] with
//         out_valid[port_sel]=1 in the NEXT cycle (1-cycle latency); other lanes 0.
//   DONE: exactly one cycle; done=1 (Moore); coincides with the last payload bit on ser_out/out_valid;
//         ser_in ignored; always -> IDLE (no start detection in DONE).
//  out_valid/ser_out are 0 in any cycle not following a DATA sample. busy = (state != IDLE).
//  Frame length in cycles after start-bit sample: PORT_W + LEN_W + len + 1 (DONE).
//  abort=1 in any non-IDLE state: next state IDLE, no done pulse, counters cleared, out_valid and ser_out
//   forced 0 next cycle (a bit sampled in the abort cycle is discarded); port_sel retains its value.
//   abort in IDLE: no effect; start bit in the same cycle is ignored.
//  Counter: single bit counter, reloaded on every phase entry; terminal count compared against
//   PORT_W-1, LEN_W-1, len-1 per state; LEN_W-bit arithmetic, no wrap possible (len<=2**LEN_W-1).
//  Unused state encodings -> IDLE next cycle with outputs at reset values.
// STRUCTURE
//  serial_seq_pkg: state localparams (IDLE, PORT, LEN, DATA, DONE, 3-bit encoding), default PORT_W/LEN_W.
//  Sub-module seq_bit_counter (load, en, terminal-count value in, tc out, width LEN_W) used for all
//   three counting phases; FSM, shift regs and output regs in this module.
// TESTING
//  1 rst held 2 cycles, ser_in=1 -> all outputs 0, busy=0; rst mid-DATA -> IDLE next cycle, outputs 0.
//  2 start, port=2'b10, len=4'b0011, data 1,0,1 -> out_valid=4'b0100 for 3 cycles, ser_out[2]=1,0,1,
//    done=1 on 3rd valid cycle, busy high 10 cycles total.
//  3 port=1, len=0 -> no out_valid, done pulses on cycle after last len bit, port_sel=1.
//  4 port=3, len=15, alternating data -> 15 valid cycles on lane 3 only, bits match in order.
//  5 abort on 2nd DATA cycle of len=5 frame -> out_valid 0 from next cycle, done never asserted, IDLE.
//  6 two frames back-to-back, start bit driven during DONE then again in IDLE -> first ignored,
//    second frame decoded correctly with new port_sel.

Source files
------------

// File: rtl/serial_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_seq_pkg
// Brief   : State encodings and default field widths for the frame sequencer
// Revision: 1.0
// ============================================================================
package serial_seq_pkg;

  localparam int PORT_W_DEFAULT = 2;
  localparam int LEN_W_DEFAULT  = 4;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PORT = 3'd1;
  localparam logic [2:0] LEN  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/serial_frame_sequencer_bit_counter.sv
`default_nettype none
// ============================================================================
// Module  : seq_bit_counter
// Brief   : Reloadable up-counter with terminal-count compare, shared by phases
// Revision: 1.0
// ============================================================================
module seq_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] tc_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == tc_val);

endmodule
`default_nettype wire

// File: rtl/serial_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : serial_frame_sequencer
// Brief   : Decodes start/address/length framing and routes payload to a lane
// Revision: 1.0
// ============================================================================
module serial_frame_sequencer
  import serial_seq_pkg::*;
#(
  parameter int PORT_W  = PORT_W_DEFAULT,
  parameter int LEN_W   = LEN_W_DEFAULT,
  parameter int N_PORTS = 2 ** PORT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ser_in,
  input  logic               abort,
  output logic [N_PORTS-1:0] ser_out,
  output logic [N_PORTS-1:0] out_valid,
  output logic [PORT_W-1:0]  port_sel,
  output logic               busy,
  output logic               done
);

  logic [2:0]         state_q, state_d;
  logic [PORT_W-1:0]  addr_q, addr_d;
  logic [PORT_W-1:0]  port_sel_q, port_sel_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [N_PORTS-1:0] ser_out_q, ser_out_d;
  logic [N_PORTS-1:0] out_valid_q, out_valid_d;

  logic               cnt_load;
  logic               cnt_en;
  logic               cnt_tc;
  logic [LEN_W-1:0]   cnt_tc_val;

  logic [PORT_W-1:0]  addr_shift;
  logic [LEN_W-1:0]   len_shift;
  logic [N_PORTS-1:0] lane_onehot;
  logic               state_legal;

  // Shift values include the bit sampled this cycle so the final decision
  // (length zero, captured address) is made without an extra cycle.
  assign addr_shift  = PORT_W'({addr_q, ser_in});
  assign len_shift   = LEN_W'({len_q, ser_in});
  assign lane_onehot = N_PORTS'(1) << port_sel_q;
  assign state_legal = (state_q == IDLE) || (state_q == PORT) || (state_q == LEN) ||
                       (state_q == DATA) || (state_q == DONE);

  seq_bit_counter #(
    .WIDTH (LEN_W)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .en     (cnt_en),
    .tc_val (cnt_tc_val),
    .tc     (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!ser_in && !abort) state_d = PORT;
      PORT: begin
        if (abort)       state_d = IDLE;
        else if (cnt_tc) state_d = LEN;
      end
      LEN: begin
        if (abort)       state_d = IDLE;
        else if (cnt_tc) state_d = (len_shift == '0) ? DONE : DATA;
      end
      DATA: begin
        if (abort)       state_d = IDLE;
        else if (cnt_tc) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    cnt_load   = (state_d != state_q);
    cnt_en     = (state_q == PORT) || (state_q == LEN) || (state_q == DATA);
    cnt_tc_val = '0;
    case (state_q)
      PORT:    cnt_tc_val = LEN_W'(PORT_W - 1);
      LEN:     cnt_tc_val = LEN_W'(LEN_W - 1);
      DATA:    cnt_tc_val = len_q - LEN_W'(1);
      default: cnt_tc_val = '0;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    port_sel_d  = port_sel_q;
    len_d       = len_q;
    ser_out_d   = '0;
    out_valid_d = '0;
    if (!state_legal) begin
      port_sel_d = '0;
    end else if (!abort) begin
      case (state_q)
        PORT: begin
          addr_d = addr_shift;
          if (cnt_tc) port_sel_d = addr_shift;
        end
        LEN:  len_d = len_shift;
        DATA: begin
          out_valid_d = lane_onehot;
          ser_out_d   = ser_in ? lane_onehot : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      port_sel_q  <= '0;
      len_q       <= '0;
      ser_out_q   <= '0;
      out_valid_q <= '0;
    end else begin
      addr_q      <= addr_d;
      port_sel_q  <= port_sel_d;
      len_q       <= len_d;
      ser_out_q   <= ser_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign out_valid = out_valid_q;
  assign port_sel  = port_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_frame_sequencer
// Brief   : Directed frames with a queue of expected lane outputs
// Revision: 1.0
// ============================================================================
module tb_serial_frame_sequencer;

  localparam int PW = 2;
  localparam int LW = 4;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ser_in;
  logic          abort;
  logic [NP-1:0] ser_out;
  logic [NP-1:0] out_valid;
  logic [PW-1:0] port_sel;
  logic          busy;
  logic          done;

  int            tests = 0;
  int            fails = 0;
  int            busy_cnt = 0;
  logic [NP:0]   exp_q[$];
  logic [PW-1:0] cur_port = '0;

  always #5 clk = ~clk;

  serial_frame_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .abort     (abort),
    .ser_out   (ser_out),
    .out_valid (out_valid),
    .port_sel  (port_sel),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then check the outputs that result from that edge.
  task automatic cyc(input logic sin, input logic ab, input logic psh, input logic eb, input logic ed);
    logic [NP:0]   e;
    logic [NP-1:0] ev;
    logic [NP-1:0] eo;
    ser_in = sin;
    abort  = ab;
    if (psh) exp_q.push_back({NP'(1) << cur_port, sin});
    @(posedge clk);
    #1;
    ev = '0;
    eo = '0;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ev = e[NP:1];
      eo = e[0] ? e[NP:1] : '0;
    end
    check("out_valid", 32'(out_valid), 32'(ev));
    check("ser_out",   32'(ser_out),   32'(eo));
    check("busy",      32'(busy),      32'(eb));
    check("done",      32'(done),      32'(ed));
    if (busy) busy_cnt++;
  endtask

  task automatic frame(input logic [PW-1:0] p, input logic [LW-1:0] len, input logic [14:0] bits,
                       input int ab_at, input logic start_in_done);
    cur_port = p;
    busy_cnt = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < PW; i++) cyc(p[PW-1-i], 1'b0, 1'b0, 1'b1, 1'b0);
    check("port_sel", 32'(port_sel), 32'(p));
    for (int i = 0; i < LW; i++) cyc(len[LW-1-i], 1'b0, 1'b0, 1'b1, (i == LW-1) && (len == '0));
    for (int k = 0; k < int'(len); k++) begin
      if (k == ab_at) begin
        cyc(bits[k], 1'b1, 1'b0, 1'b0, 1'b0);
        return;
      end
      cyc(bits[k], 1'b0, 1'b1, 1'b1, k == int'(len) - 1);
    end
    cyc(start_in_done ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("busy_cycles", 32'(busy_cnt), 32'(PW + LW + int'(len) + 1));
  endtask

  initial begin
    rst    = 1'b1;
    ser_in = 1'b1;
    abort  = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_port_sel", 32'(port_sel), 32'd0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort coinciding with a start bit in IDLE must not start a frame.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    frame(2'b10, 4'b0011, 15'b101, -1, 1'b0);
    frame(2'b01, 4'b0000, 15'b0, -1, 1'b0);
    check("port_sel_len0", 32'(port_sel), 32'd1);
    frame(2'b11, 4'b1111, 15'b101010101010101, -1, 1'b0);

    frame(2'b00, 4'd5, 15'b10110, 1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("port_sel_after_abort", 32'(port_sel), 32'd0);

    frame(2'b11, 4'd2, 15'b01, -1, 1'b1);
    frame(2'b01, 4'd3, 15'b110, -1, 1'b0);
    check("port_sel_b2b", 32'(port_sel), 32'd1);

    // Reset in the middle of a payload.
    cur_port = 2'b10;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_port_sel", 32'(port_sel), 32'd0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
